input_reg_fifo: RTL and testbench
=================================

// Module: input_reg_fifo
// PURPOSE
//  Parametrised successor of the 4-bit enable-gated input register: captures W-bit input words on EnableIn
//  into a DEPTH-entry first-word-fall-through buffer and presents them on B with valid/ready handshake.
//  Sits between the external data pins and the core datapath; absorbs bursts while the core stalls.
//  Output drive is gated by OutEnable (bus-style sharing), as in the previous generation.
// PARAMETERS
//  W       4   data word width (bits), >= 1
//  DEPTH   4   buffer entries, power of two, >= 2
//  CW      $clog2(DEPTH)+1   occupancy counter width (derived, not overridable)
// PORTS
//  Clk        in   1      single clock, rising edge
//  ResetN     in   1      asynchronous active-low reset
//  DataIn     in   W      input word
//  EnableIn   in   1      producer valid; word accepted when EnableIn && ReadyIn at Clk rise
//  ReadyIn    out  1      buffer can accept (not full)
//  B          out  W      head-of-buffer word
//  ValidOut   out  1      B holds a valid word (not empty)
//  ReadyOut   in   1      consumer ready; pop when ValidOut && ReadyOut at Clk rise
//  OutEnable  in   1      B drive enable (see CONFIGURATION)
//  Count      out  CW     current occupancy 0..DEPTH
//  Overflow   out  1      sticky: EnableIn asserted while ReadyIn low
// BEHAVIOUR
//  - Reset (ResetN low, async, any time incl. mid-transfer): wr/rd pointers 0, Count 0, ValidOut 0,
//    ReadyIn 1, Overflow 0, B = 0 (or Z, see CONFIGURATION). Buffer contents not cleared, never exposed.
//  - push = EnableIn & ReadyIn; pop = ValidOut & ReadyOut; both evaluated on registered flags.
//  - Write latency: word pushed at edge N appears on B with ValidOut=1 after edge N (1 cycle); no
//    same-cycle bypass when empty.
//  - FWFT: B always shows entry at rd pointer; B stable while ValidOut && !ReadyOut.
//  - Count: +1 push only, -1 pop only, unchanged on push&pop or neither. ReadyIn = (Count != DEPTH);
//    ValidOut = (Count != 0). All flags registered/derived from registered Count; no combinational
//    path EnableIn->ReadyIn or ReadyOut->ValidOut.
//  - Full + pop + EnableIn same cycle: pop happens, push refused (ReadyIn was 0), Overflow set.
//  - Empty + push + ReadyOut same cycle: push happens, no pop (ValidOut was 0).
//  - Pointers are log2(DEPTH) bits, wrap modulo DEPTH naturally; Count never exceeds DEPTH or goes <0.
//  - Overflow: set on EnableIn & !ReadyIn; cleared only by ResetN. Dropped word is discarded.
//  - OutEnable affects only B drive; handshake and pointers unaffected by it.
// CONFIGURATION
//  INPUT_REG_TRISTATE_EN defined: B driven via bufif1-style tri-state, B = 'z when OutEnable=0
//    (and during reset), head word when OutEnable=1.
//  Not defined: B = head word when OutEnable=1, all-zero when OutEnable=0; never 'z.
// STRUCTURE
//  Package input_reg_pkg: default W/DEPTH constants, clog2 helper function.
//  Sub-module input_reg_mem: DEPTH x W register array, 1 write port (clocked), 1 async read port;
//    no reset on the array. Pointer/count/flag logic and output drive live in input_reg_fifo.
// TESTING
//  1 Reset: ResetN=0 mid-stream with Count=3 -> immediately Count=0, ValidOut=0, ReadyIn=1, Overflow=0.
//  2 Single word: DataIn=4'hA, EnableIn 1 cycle, ReadyOut=0 -> next cycle ValidOut=1, B=4'hA, Count=1.
//  3 Fill/drain: push 1,2,3,4 (DEPTH=4) ReadyOut=0 -> ReadyIn=0, Count=4; then ReadyOut=1 -> B=1,2,3,4
//    on successive cycles, ValidOut falls after 4th pop, pointers wrap, push 5 -> B=5.
//  4 Full + simultaneous: Count=4, EnableIn=1 DataIn=9, ReadyOut=1 -> head popped, 9 dropped,
//    Count=3, Overflow=1 and stays 1 until reset.
//  5 Streaming: EnableIn=1, ReadyOut=1 continuous from Count=2, data 0..15 -> Count stays 2, order kept.
//  6 OutEnable=0 with Count=1: B=zzzz with INPUT_REG_TRISTATE_EN, 4'h0 without; ValidOut unaffected.

Source files
------------

// File: rtl/input_reg_pkg.sv
// Shared defaults and elaboration helpers for the input register FIFO.
// Optional tri-state drive of B is selected with INPUT_REG_TRISTATE_EN.
package input_reg_pkg;

    localparam int W_DEF     = 4;
    localparam int DEPTH_DEF = 4;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/input_reg_mem.sv
// DEPTH x W storage array: one clocked write port, one asynchronous read port.
// Contents are deliberately not reset; the control logic never exposes stale entries.
module input_reg_mem
    import input_reg_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [clog2(DEPTH)-1:0]   waddr_i,
    input  logic [W-1:0]              wdata_i,
    input  logic [clog2(DEPTH)-1:0]   raddr_i,
    output logic [W-1:0]              rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/input_reg_fifo.sv
// First-word-fall-through input buffer with valid/ready handshake on both sides.
// Define INPUT_REG_TRISTATE_EN to float B when OutEnable is low or reset is active.
module input_reg_fifo
    import input_reg_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    Clk,
    input  logic                    ResetN,
    input  logic [W-1:0]            DataIn,
    input  logic                    EnableIn,
    output logic                    ReadyIn,
    output logic [W-1:0]            B,
    output logic                    ValidOut,
    input  logic                    ReadyOut,
    input  logic                    OutEnable,
    output logic [clog2(DEPTH):0]   Count,
    output logic                    Overflow
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshake: a word moves on a side when its valid and ready are both high at the
    // rising edge; ReadyIn/ValidOut depend only on the registered count.
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push, pop;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  head_word;

    assign ReadyIn  = (count_q != CW'(DEPTH));
    assign ValidOut = (count_q != '0);
    assign Count    = count_q;
    assign Overflow = overflow_q;

    assign push = EnableIn & ReadyIn;
    assign pop  = ValidOut & ReadyOut;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (EnableIn & ~ReadyIn);
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    input_reg_mem #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (Clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (DataIn),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Stale array contents stay hidden while the buffer is empty.
    assign head_word = ValidOut ? rd_data : '0;

`ifdef INPUT_REG_TRISTATE_EN
    assign B = (OutEnable && ResetN) ? head_word : 'z;
`else
    assign B = OutEnable ? head_word : '0;
`endif

endmodule

// File: tb/tb_input_reg_fifo.sv
// Self-checking bench for input_reg_fifo against a queue-based reference model.
// Honours INPUT_REG_TRISTATE_EN when checking B with OutEnable low.
module tb_input_reg_fifo;
    import input_reg_pkg::*;

    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = clog2(DEPTH) + 1;

    logic          Clk = 1'b0;
    logic          ResetN = 1'b0;
    logic [W-1:0]  DataIn = '0;
    logic          EnableIn = 1'b0;
    logic          ReadyOut = 1'b0;
    logic          OutEnable = 1'b1;
    wire           ReadyIn, ValidOut, Overflow;
    wire [W-1:0]   B;
    wire [CW-1:0]  Count;

    logic [W-1:0] exp_q[$];
    logic         exp_ovf = 1'b0;
    int           errors = 0;
    int           checks = 0;

    always #5 Clk = ~Clk;

    input_reg_fifo #(.W(W), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .ResetN(ResetN), .DataIn(DataIn), .EnableIn(EnableIn),
        .ReadyIn(ReadyIn), .B(B), .ValidOut(ValidOut), .ReadyOut(ReadyOut),
        .OutEnable(OutEnable), .Count(Count), .Overflow(Overflow)
    );

    // One clock of stimulus; the model decides push/pop from its pre-edge occupancy.
    task automatic step(input logic en, input logic [W-1:0] d, input logic rdy);
        bit full, empty;
        EnableIn = en; DataIn = d; ReadyOut = rdy;
        @(posedge Clk);
        full  = (exp_q.size() == DEPTH);
        empty = (exp_q.size() == 0);
        if (en && full) exp_ovf = 1'b1;
        if (rdy && !empty) void'(exp_q.pop_front());
        if (en && !full) exp_q.push_back(d);
        @(negedge Clk);
        EnableIn = 1'b0; ReadyOut = 1'b0;
    endtask

    task automatic test_reset_initial();
        #1;
        checks++; if (Count !== '0) begin errors++; $display("FAIL init_count: got %0d exp 0", Count); end
        checks++; if (ValidOut !== 1'b0) begin errors++; $display("FAIL init_valid: got %b exp 0", ValidOut); end
        checks++; if (ReadyIn !== 1'b1) begin errors++; $display("FAIL init_ready: got %b exp 1", ReadyIn); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL init_ovf: got %b exp 0", Overflow); end
`ifdef INPUT_REG_TRISTATE_EN
        checks++; if (B !== 4'bzzzz) begin errors++; $display("FAIL init_b: got %b exp zzzz", B); end
`else
        checks++; if (B !== 4'h0) begin errors++; $display("FAIL init_b: got %b exp 0000", B); end
`endif
        @(negedge Clk);
        ResetN = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_single_word();
        step(1'b1, 4'hA, 1'b0);
        checks++; if (ValidOut !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", ValidOut); end
        checks++; if (B !== 4'hA) begin errors++; $display("FAIL single_b: got %h exp a", B); end
        checks++; if (Count !== CW'(1)) begin errors++; $display("FAIL single_count: got %0d exp 1", Count); end
        step(1'b0, 4'h0, 1'b1);
        checks++; if (ValidOut !== 1'b0) begin errors++; $display("FAIL single_drain: got %b exp 0", ValidOut); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b0);
        checks++; if (ReadyIn !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b exp 0", ReadyIn); end
        checks++; if (Count !== CW'(4)) begin errors++; $display("FAIL fill_count: got %0d exp 4", Count); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (B !== W'(i)) begin errors++; $display("FAIL drain_b: got %h exp %h", B, W'(i)); end
            checks++; if (B !== exp_q[0]) begin errors++; $display("FAIL drain_model: got %h exp %h", B, exp_q[0]); end
            step(1'b0, 4'h0, 1'b1);
        end
        checks++; if (ValidOut !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b exp 0", ValidOut); end
        step(1'b1, 4'h5, 1'b0);
        checks++; if (B !== 4'h5) begin errors++; $display("FAIL wrap_b: got %h exp 5", B); end
        step(1'b0, 4'h0, 1'b1);
    endtask

    task automatic test_full_simultaneous();
        for (int i = 0; i < 4; i++) step(1'b1, W'(4'hC + i), 1'b0);
        step(1'b1, 4'h9, 1'b1);
        checks++; if (Count !== CW'(3)) begin errors++; $display("FAIL fullsim_count: got %0d exp 3", Count); end
        checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL fullsim_ovf: got %b exp 1", Overflow); end
        checks++; if (B !== 4'hD) begin errors++; $display("FAIL fullsim_b: got %h exp d", B); end
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b0);
        checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b exp 1", Overflow); end
    endtask

    task automatic test_reset_midstream();
        while (exp_q.size() < 3) step(1'b1, W'($urandom_range(0, 15)), 1'b0);
        checks++; if (Count !== CW'(3)) begin errors++; $display("FAIL pre_reset_count: got %0d exp 3", Count); end
        #2 ResetN = 1'b0;
        exp_q.delete(); exp_ovf = 1'b0;
        #1;
        checks++; if (Count !== '0) begin errors++; $display("FAIL rst_count: got %0d exp 0", Count); end
        checks++; if (ValidOut !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", ValidOut); end
        checks++; if (ReadyIn !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", ReadyIn); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b exp 0", Overflow); end
        @(negedge Clk);
        ResetN = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_streaming();
        step(1'b1, 4'hE, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, W'(i), 1'b1);
            checks++; if (Count !== CW'(2)) begin errors++; $display("FAIL stream_count: got %0d exp 2", Count); end
            checks++; if (B !== exp_q[0]) begin errors++; $display("FAIL stream_b: got %h exp %h", B, exp_q[0]); end
        end
        checks++; if (B !== 4'hE) begin errors++; $display("FAIL stream_last: got %h exp e", B); end
        step(1'b0, 4'h0, 1'b1);
        step(1'b0, 4'h0, 1'b1);
    endtask

    task automatic test_out_enable();
        step(1'b1, 4'h7, 1'b0);
        OutEnable = 1'b0;
        #1;
`ifdef INPUT_REG_TRISTATE_EN
        checks++; if (B !== 4'bzzzz) begin errors++; $display("FAIL oe_b: got %b exp zzzz", B); end
`else
        checks++; if (B !== 4'h0) begin errors++; $display("FAIL oe_b: got %b exp 0000", B); end
`endif
        checks++; if (ValidOut !== 1'b1) begin errors++; $display("FAIL oe_valid: got %b exp 1", ValidOut); end
        OutEnable = 1'b1;
        #1;
        checks++; if (B !== 4'h7) begin errors++; $display("FAIL oe_restore: got %h exp 7", B); end
        @(negedge Clk);
        step(1'b0, 4'h0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            OutEnable = ($urandom_range(0, 7) != 0);
            step($urandom_range(0, 1) == 1, W'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
            checks++;
            if (Count !== CW'(exp_q.size()) || ValidOut !== (exp_q.size() != 0) ||
                ReadyIn !== (exp_q.size() != DEPTH) || Overflow !== exp_ovf) begin
                errors++;
                $display("FAIL rand_flags: got cnt=%0d v=%b r=%b o=%b exp cnt=%0d o=%b",
                         Count, ValidOut, ReadyIn, Overflow, exp_q.size(), exp_ovf);
            end
            if (OutEnable && exp_q.size() != 0) begin
                checks++;
                if (B !== exp_q[0]) begin errors++; $display("FAIL rand_b: got %h exp %h", B, exp_q[0]); end
            end
        end
        OutEnable = 1'b1;
    endtask

    initial begin
        test_reset_initial();
        test_single_word();
        test_fill_drain();
        test_full_simultaneous();
        test_reset_midstream();
        test_streaming();
        test_out_enable();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
